// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans one SLICE_W slice per cycle, MSB slice first.
// Optional EARLY_TERM_EN: leave CMP as soon as the first differing slice is seen.
module seq_magnitude_comparator #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             less,
  output logic             greater
);
  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state, state_nx;

  logic [NSLICES-1:0][SLICE_W-1:0] a_q, b_q;
  logic [IDX_W-1:0]                idx;
  logic                            decided, lt_q, gt_q;
  logic [SLICE_W-1:0]              sa, sb;
  logic                            lt_n, gt_n, cmp_end, accept;

  assign accept = start && (state != CMP);
  assign sa     = a_q[idx];
  assign sb     = b_q[idx];

  // Once a slice differs, the decision is frozen for the remaining slices.
  always_comb begin
    lt_n = decided ? lt_q : (sa < sb);
    gt_n = decided ? gt_q : (sa > sb);
`ifdef EARLY_TERM_EN
    cmp_end = (idx == '0) || lt_n || gt_n;
`else
    cmp_end = (idx == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CMP;
      CMP:     if (cmp_end) state_nx = DONE;
      DONE:    state_nx = start ? CMP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CMP);
    done = (state == DONE);
  end

  // Signed mode flips the sign bits so an unsigned scan orders two's-complement values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      equal   <= 1'b0;
      less    <= 1'b0;
      greater <= 1'b0;
    end else if (accept) begin
      a_q     <= a ^ (signed_mode ? MSB_MASK : '0);
      b_q     <= b ^ (signed_mode ? MSB_MASK : '0);
      idx     <= LAST_IDX;
      decided <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else if (state == CMP) begin
      idx     <= idx - IDX_W'(1);
      decided <= lt_n || gt_n;
      lt_q    <= lt_n;
      gt_q    <= gt_n;
      if (cmp_end) begin
        equal   <= !(lt_n || gt_n);
        less    <= lt_n;
        greater <= gt_n;
      end
    end
  end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (16/4) plus random sweeps on 8/4 and 8/8.
module tb_seq_magnitude_comparator;
`ifdef EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001;

  logic        clk = 1'b0;
  logic        rst, start, signed_mode;
  logic [15:0] a, b;
  logic        busy, done, equal, less, greater;
  logic [1:0]  start8, busy8, done8, eq8, lt8, gt8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy), .done(done), .equal(equal), .less(less), .greater(greater));

  seq_magnitude_comparator #(.WIDTH(8), .SLICE_W(4)) dut84 (
    .clk(clk), .rst(rst), .start(start8[0]), .signed_mode(signed_mode), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8[0]), .done(done8[0]), .equal(eq8[0]), .less(lt8[0]), .greater(gt8[0]));

  seq_magnitude_comparator #(.WIDTH(8), .SLICE_W(8)) dut88 (
    .clk(clk), .rst(rst), .start(start8[1]), .signed_mode(signed_mode), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8[1]), .done(done8[1]), .equal(eq8[1]), .less(lt8[1]), .greater(gt8[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start in cycle 0, then check busy/done every cycle through the expected done cycle.
  task automatic run16(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic sm, input int dcyc, input logic [2:0] res);
    @(negedge clk); a = va; b = vb; signed_mode = sm; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= dcyc; c++) begin
      if (c > 1) @(negedge clk);
      chk({tag, " busy"}, busy, 32'(c < dcyc));
      chk({tag, " done"}, done, 32'(c == dcyc));
    end
    chk({tag, " result"}, {less, equal, greater}, res);
  endtask

  task automatic run8(input int s, input int nsl);
    logic [7:0] va, vb, oa, ob, diff;
    logic       sm, busy_ok;
    logic [2:0] res;
    int         sw, k, dexp, cyc;
    va = 8'($urandom); vb = 8'($urandom); sm = 1'($urandom);
    if ($urandom_range(0, 7) == 0) vb = va;
    if (sm) res = ($signed(va) < $signed(vb)) ? LT : ($signed(va) > $signed(vb)) ? GT : EQ;
    else    res = (va < vb) ? LT : (va > vb) ? GT : EQ;
    oa = va ^ (sm ? 8'h80 : 8'h00);
    ob = vb ^ (sm ? 8'h80 : 8'h00);
    diff = oa ^ ob;
    sw = 8 / nsl;
    k = 0;
    for (int j = 0; j < nsl; j++)
      if (k == 0 && ((int'(diff) >> (8 - (j + 1) * sw)) & ((1 << sw) - 1)) != 0) k = j + 1;
    dexp = (ET && k != 0) ? k + 1 : nsl + 1;
    @(negedge clk); a[7:0] = va; b[7:0] = vb; signed_mode = sm; start8[s] = 1'b1;
    @(negedge clk); start8[s] = 1'b0;
    cyc = 1; busy_ok = 1'b1;
    while (!done8[s] && cyc < 20) begin
      if (!busy8[s]) busy_ok = 1'b0;
      @(negedge clk); cyc++;
    end
    chk($sformatf("sweep%0d done_cycle a=%h b=%h sm=%0d", s, va, vb, sm), cyc, dexp);
    chk($sformatf("sweep%0d busy", s), {31'b0, busy_ok}, 32'd1);
    chk($sformatf("sweep%0d result a=%h b=%h sm=%0d", s, va, vb, sm),
        {lt8[s], eq8[s], gt8[s]}, res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start8 = '0; signed_mode = 1'b0; a = '0; b = '0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", {less, equal, greater}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run16("t1 unsigned 1234<1235", 16'h1234, 16'h1235, 1'b0, 5, LT);
    run16("t2 signed 8000<0001", 16'h8000, 16'h0001, 1'b1, ET ? 2 : 5, LT);
    run16("t2 unsigned 8000>0001", 16'h8000, 16'h0001, 1'b0, ET ? 2 : 5, GT);
    run16("t2 signed FFFF==FFFF", 16'hFFFF, 16'hFFFF, 1'b1, 5, EQ);
    run16("t3 F000>0000", 16'hF000, 16'h0000, 1'b0, ET ? 2 : 5, GT);
    run16("t3 BEEF==BEEF", 16'hBEEF, 16'hBEEF, 1'b0, 5, EQ);

    // Start during busy is ignored; operand changes after accept have no effect.
    @(negedge clk); a = 16'h1234; b = 16'h1235; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 16'hFFFF; b = 16'h0000;
    @(negedge clk); start = 1'b0;
    chk("t4a busy c3", busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t4a done c5", done, 1);
    chk("t4a result", {less, equal, greater}, LT);
    @(negedge clk);
    chk("t4a no 2nd op busy c6", busy, 0);
    chk("t4a no 2nd done c6", done, 0);

    // Back-to-back start in the done cycle.
    @(negedge clk); a = 16'h1234; b = 16'h1235; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4b done c5", done, 1);
    chk("t4b result c5", {less, equal, greater}, LT);
    start = 1'b1; a = 16'h0005; b = 16'h0003;
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk); start = 1'b0;
      chk($sformatf("t4b busy c%0d", c), busy, 1);
      chk($sformatf("t4b hold c%0d", c), {less, equal, greater}, LT);
    end
    @(negedge clk);
    chk("t4b done c10", done, 1);
    chk("t4b result c10", {less, equal, greater}, GT);

    // Reset in cycle 2 aborts the compare.
    @(negedge clk); a = 16'h1234; b = 16'h1235; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("t5 rst busy", busy, 0);
    chk("t5 rst done", done, 0);
    chk("t5 rst result", {less, equal, greater}, 3'b000);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5 no done after rst", done, 0);
    end
    run16("t5 after rst", 16'h0003, 16'h0003, 1'b0, 5, EQ);

    for (int i = 0; i < 1000; i++) run8(0, 2);
    for (int i = 0; i < 1000; i++) run8(1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
